acc_core: RTL
=============

# acc_core

Parametrised accumulator core combining the program counter, ALU and W register into one sequenced block. Accepts one instruction per valid/ready handshake, updates the W accumulator plus carry/zero flags, and counts accepted instructions. Adds an add-with-carry opcode and an iterative multi-cycle multiply. Sits between the instruction source and the register file/bus as the datapath's execution unit.

## Interface

- WIDTH, 16, data width of `b` and `w`.
- PCW, 16, width of the instruction counter `counter`.

Ports:

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; `reset=0` clears all state immediately.
- in_valid  input  1  instruction/operand present.
- in_ready  output  1  core can accept an instruction this cycle.
- inst  input  4  opcode.
- b  input  WIDTH  operand.
- w  output  WIDTH  accumulator, registered.
- carry  output  1  carry/borrow flag, registered.
- zero  output  1  high when `w == 0`, registered together with `w`.
- done  output  1  one-cycle pulse: the result of an instruction is visible on `w` this cycle.
- counter  output  PCW  number of accepted instructions, modulo 2^PCW.

## Operation

Handshake:

- An instruction is accepted on a rising edge where `in_valid && in_ready`.
- `counter` increments by 1 on every acceptance and wraps from 2^PCW-1 to 0.
- In `IDLE`, `in_ready` is high.
- `in_valid` while `in_ready=0` is ignored; no queuing.

Opcodes (w' is the new value; flags are unchanged unless listed):

- 0 LOAD: w'=b.
- 1 ADD: {carry,w'} = w+b, computed at WIDTH+1 bits.
- 2 SUB: w' = (w-b) mod 2^WIDTH; carry = 1 if b > w (borrow).
- 3 AND, 4 OR, 5 XOR: bitwise with `b`.
- 6 NOT: w'=~w.
- 7 SHL: w'=w<<1; carry = old w[WIDTH-1].
- 8 SHR: logical shift, w'=w>>1; carry = old w[0].
- 9 ADC: {carry,w'} = w+b+carry.
- 10 MUL: w' = low WIDTH bits of w*b; carry = 1 if the high WIDTH bits are nonzero.
- 11 CLR: w'=0, carry=0.
- 12–15 NOP: w and carry unchanged. Still accepted, still counted, still pulse `done`.

`zero` is always recomputed from w' whenever `w` is written (also on NOP, where it keeps its value).

State machine:

- IDLE → IDLE on acceptance of a single-cycle opcode (all opcodes except 10).
- IDLE → MUL on acceptance of opcode 10.
  - On acceptance, latch multiplicand = w, multiplier = b, partial product = 0, iteration count = 0.
- MUL: one shift-add step per cycle, WIDTH steps in total, using a 2·WIDTH-bit partial product.
- After the final step, write w, carry and zero, then return to IDLE.
- The multiplier must not be a combinational WIDTH×WIDTH product.

Reset (`reset=0`, asynchronous, including mid-MUL): w=0, carry=0, zero=1, done=0, counter=0, state IDLE, `in_ready=1` once reset is released. Any in-flight MUL is discarded.

## Timing

- Single-cycle op accepted at edge N: w, carry and zero are updated at edge N; `done`=1 during cycle N→N+1. Back-to-back acceptance is allowed every cycle.
- MUL accepted at edge N:
  - `in_ready`=0 from edge N through edge N+WIDTH-1.
  - The result is written at edge N+WIDTH.
  - `done`=1 and `in_ready`=1 during cycle N+WIDTH→N+WIDTH+1, so the next instruction can be accepted at edge N+WIDTH+1.
  - Latency is WIDTH cycles.
- `w` and the flags hold their previous values throughout a MUL; no intermediate value is ever visible.
- `done`=0 in every cycle not listed above.
- `counter` updates at the accepting edge, not at completion.

## Test plan

- Reset and idle: pulse `reset` low mid-cycle → w=0, carry=0, zero=1, counter=0, in_ready=1 immediately, with no dependence on clk.
- Single-cycle ops (WIDTH=16), one per cycle:
  - LOAD 10 → w=10.
  - ADD 3 → w=13, carry=0.
  - SUB 20 → w=65529, carry=1.
  - ADC 6 → w=0, carry=1, zero=1.
  - Expected counter=4; `done` high for 4 consecutive cycles.
- Shifts and logic: LOAD 0x8001, SHL → w=0x0002, carry=1. Then SHR → w=0x0001, carry=0. Then XOR 0x00FF → 0x00FE. Then NOT → 0xFF01.
- Multiply: LOAD 300, MUL 300 →
  - in_ready=0 for 16 cycles;
  - w=24464 (90000 mod 65536), carry=1, `done` high 16 cycles after acceptance.
  - MUL 3 on w=5 → w=15, carry=0.
- Busy protection: hold in_valid=1 with ADD 1 throughout a MUL → only one ADD is accepted, after MUL completes; counter advances by exactly 2.
- Reset mid-MUL: assert reset at iteration 7 → w=0, zero=1, no `done` pulse. After release, LOAD 4 is accepted on the first cycle with counter=1.

Source files
------------

// File: rtl/acc_core.sv
// rtl/acc_core.sv - accumulator execution core: W register, carry/zero flags,
// accepted-instruction counter and a WIDTH-cycle shift-add multiplier.
module acc_core #(
   parameter int WIDTH = 16,
   parameter int PCW   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       inst,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] w,
   output logic             carry,
   output logic             zero,
   output logic             done,
   output logic [PCW-1:0]   counter
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_ITER = IW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   w_q, w_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;
   logic               done_q, done_d;
   logic [PCW-1:0]     pc_q, pc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [IW-1:0]      iter_q, iter_d;
   logic [WIDTH:0]     sum;

   assign in_ready = (state_q == S_IDLE);
   assign w        = w_q;
   assign carry    = carry_q;
   assign zero     = zero_q;
   assign done     = done_q;
   assign counter  = pc_q;

   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      pc_d     = pc_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      iter_d   = iter_q;
      sum      = '0;
      if (state_q == S_IDLE) begin
         if (in_valid) begin
            pc_d   = pc_q + PCW'(1);
            done_d = 1'b1;
            case (inst)
               4'd0: w_d = b;
               4'd1: begin
                  sum = {1'b0, w_q} + {1'b0, b};
                  {carry_d, w_d} = sum;
               end
               4'd2: begin
                  w_d     = w_q - b;
                  carry_d = (b > w_q);
               end
               4'd3: w_d = w_q & b;
               4'd4: w_d = w_q | b;
               4'd5: w_d = w_q ^ b;
               4'd6: w_d = ~w_q;
               4'd7: begin
                  w_d     = w_q << 1;
                  carry_d = w_q[WIDTH-1];
               end
               4'd8: begin
                  w_d     = w_q >> 1;
                  carry_d = w_q[0];
               end
               4'd9: begin
                  sum = {1'b0, w_q} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
                  {carry_d, w_d} = sum;
               end
               4'd10: begin
                  // w and flags stay frozen until the last shift-add step
                  done_d   = 1'b0;
                  state_d  = S_MUL;
                  mcand_d  = {{WIDTH{1'b0}}, w_q};
                  mplier_d = b;
                  prod_d   = '0;
                  iter_d   = '0;
               end
               4'd11: begin
                  w_d     = '0;
                  carry_d = 1'b0;
               end
               default: ;
            endcase
            zero_d = (w_d == '0);
         end
      end else begin
         prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         iter_d   = iter_q + IW'(1);
         if (iter_q == LAST_ITER) begin
            w_d     = prod_d[WIDTH-1:0];
            carry_d = |prod_d[2*WIDTH-1:WIDTH];
            zero_d  = (w_d == '0);
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         w_q      <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         pc_q     <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         iter_q   <= '0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
         pc_q     <= pc_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         iter_q   <= iter_d;
      end
   end

endmodule
